// File: rtl/chdr_eth_deframer_if.sv
// AXI-stream bundle for the CHDR ingress path: 64-bit data, 4-bit user sideband.
interface chdr_eth_deframer_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned USER_W = 4
);
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/chdr_eth_deframer.sv
// Strips the 6-line pad/ETH/IPv4/UDP header from ingress frames and forwards bare CHDR.
// Optional feature macro: DEFRAMER_DROP_CNT_EN (saturating dropped-frame counter).
module chdr_eth_deframer #(
  parameter int unsigned BASE      = 0,
  parameter int unsigned HDR_LINES = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  set_stb,
  input  logic [7:0]            set_addr,
  input  logic [31:0]           set_data,
  chdr_eth_deframer_if.slave    in_bus,
  chdr_eth_deframer_if.master   out_bus,
  output logic [31:0]           drop_count
);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = $clog2(HDR_LINES);
  localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'(HDR_LINES - 1);
  localparam logic [7:0]       ADDR_CFG   = 8'(BASE);
  localparam logic [7:0]       ADDR_CLR   = 8'(BASE + 1);

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   line_cnt;
  logic               hdr_fail;
  logic               run;
  logic [15:0]        cfg_port;
  logic               cfg_en;
  logic [15:0]        act_port;
  logic               act_en;
  logic [DATA_W-1:0]  out_tdata;
  logic               out_tlast;
  logic               out_tvalid;

  logic in_tready_c;
  logic in_fire_c;
  logic line_bad_c;
  logic cfg_wr_c;
  logic unused_ok;

  assign unused_ok = ^{set_data[31:17], in_bus.tuser[2:0]};

  // Header lines are always accepted; payload honours the one-entry output stage.
  assign in_tready_c = run && ((state != S_PAYLOAD) || !out_tvalid || out_bus.tready);
  assign in_fire_c   = in_bus.tvalid && in_tready_c;
  assign cfg_wr_c    = set_stb && (set_addr == ADDR_CFG);

  // Per-line header check; the sticky flag accumulates across the header.
  always_comb begin
    line_bad_c = in_bus.tuser[3];
    if ((line_cnt == CNT_W'(2)) && (in_bus.tdata[47:32] != 16'h0800))
      line_bad_c = 1'b1;
    if ((line_cnt == CNT_W'(3)) && (in_bus.tdata[23:16] != 8'h11))
      line_bad_c = 1'b1;
    if ((line_cnt == LAST_LINE) && act_en && (in_bus.tdata[47:32] != act_port))
      line_bad_c = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_HDR;
      line_cnt   <= '0;
      hdr_fail   <= 1'b0;
      run        <= 1'b0;
      cfg_port   <= '0;
      cfg_en     <= 1'b0;
      act_port   <= '0;
      act_en     <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      out_tvalid <= 1'b0;
    end else begin
      run <= 1'b1;
      if (cfg_wr_c) begin
        cfg_port <= set_data[15:0];
        cfg_en   <= set_data[16];
      end
      if (out_tvalid && out_bus.tready)
        out_tvalid <= 1'b0;

      if (clear) begin
        state      <= S_HDR;
        line_cnt   <= '0;
        hdr_fail   <= 1'b0;
        out_tvalid <= 1'b0;
      end else if (in_fire_c) begin
        unique case (state)
          S_HDR: begin
            // Port config is sampled once per frame so it never changes mid-frame.
            if (line_cnt == '0) begin
              act_port <= cfg_port;
              act_en   <= cfg_en;
            end
            if (in_bus.tlast || (line_cnt == LAST_LINE)) begin
              line_cnt <= '0;
              hdr_fail <= 1'b0;
              if (in_bus.tlast)
                state <= S_HDR;
              else if (hdr_fail || line_bad_c)
                state <= S_DROP;
              else
                state <= S_PAYLOAD;
            end else begin
              line_cnt <= line_cnt + CNT_W'(1);
              hdr_fail <= hdr_fail || line_bad_c;
            end
          end
          S_PAYLOAD: begin
            out_tdata  <= in_bus.tdata;
            out_tlast  <= in_bus.tlast;
            out_tvalid <= 1'b1;
            if (in_bus.tlast)
              state <= S_HDR;
          end
          S_DROP: begin
            if (in_bus.tlast)
              state <= S_HDR;
          end
          default: state <= S_HDR;
        endcase
      end
    end
  end

  assign in_bus.tready  = in_tready_c;
  assign out_bus.tdata  = out_tdata;
  assign out_bus.tlast  = out_tlast;
  assign out_bus.tvalid = out_tvalid;
  assign out_bus.tuser  = '0;

`ifdef DEFRAMER_DROP_CNT_EN
  logic        drop_evt_c;
  logic        clr_wr_c;
  logic [31:0] drop_q;

  // Runts end in S_HDR; failed checks end in S_DROP; both count on their tlast.
  assign drop_evt_c = in_fire_c && !clear && in_bus.tlast &&
                      ((state == S_HDR) || (state == S_DROP));
  assign clr_wr_c   = set_stb && (set_addr == ADDR_CLR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_q <= '0;
    else if (clr_wr_c)
      drop_q <= '0;
    else if (drop_evt_c && (drop_q != 32'hFFFF_FFFF))
      drop_q <= drop_q + 32'd1;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_chdr_eth_deframer.sv
// Directed bench for chdr_eth_deframer: header checks, runts, back-pressure, reset/clear.
module tb_chdr_eth_deframer;
`ifdef DEFRAMER_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] drop_count;

  chdr_eth_deframer_if in_bus ();
  chdr_eth_deframer_if out_bus ();

  chdr_eth_deframer #(.BASE(0), .HDR_LINES(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .in_bus     (in_bus.slave),
    .out_bus    (out_bus.master),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cycles = 0;
  int rdy_mode = 0;
  logic [64:0] exp_q[$];
  logic [64:0] held;
  bit          held_v = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // out_tready pattern: 0 = always ready, 1 = toggle, 2 = stalled.
  initial begin
    out_bus.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_bus.tready = 1'b1;
        1:       out_bus.tready = ~out_bus.tready;
        default: out_bus.tready = 1'b0;
      endcase
    end
  end

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (held_v && out_bus.tvalid)
        check("stall_stable", 64'({out_bus.tlast, out_bus.tdata} ^ held), 64'd0);
      if (out_bus.tvalid && out_bus.tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'd1, 64'd0);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("beat_data", out_bus.tdata, e[63:0]);
          check("beat_last", 64'(out_bus.tlast), 64'(e[64]));
        end
      end
    end
    held_v = reset_n && out_bus.tvalid && !out_bus.tready;
    held   = {out_bus.tlast, out_bus.tdata};
  end

  task automatic beat(input logic [63:0] d, input logic [3:0] u, input logic l);
    int n;
    n = 0;
    in_bus.tdata  = d;
    in_bus.tuser  = u;
    in_bus.tlast  = l;
    in_bus.tvalid = 1'b1;
    @(negedge clk);
    while (!in_bus.tready && n < 200) begin
      @(negedge clk);
      n++;
      stall_cycles++;
    end
    if (!in_bus.tready) check("in_tready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_bus.tvalid = 1'b0;
    in_bus.tlast  = 1'b0;
  endtask

  function automatic logic [63:0] hdr_line(input int i, input logic [15:0] et,
                                           input logic [7:0] pr, input logic [15:0] port);
    logic [63:0] d;
    d = 64'h0102_0304_0506_0700 | 64'(i);
    if (i == 2) d[47:32] = et;
    if (i == 3) d[23:16] = pr;
    if (i == 5) d[47:32] = port;
    return d;
  endfunction

  task automatic send_hdr(input logic [15:0] et, input logic [7:0] pr,
                          input logic [15:0] port, input int err_line);
    for (int i = 0; i < 6; i++)
      beat(hdr_line(i, et, pr, port), (i == err_line) ? 4'h8 : 4'h0, 1'b0);
  endtask

  task automatic send_pay(input int n, input logic [63:0] seed, input bit expect_out,
                          input bit chk_lat);
    for (int j = 0; j < n; j++) begin
      logic [63:0] d;
      logic        l;
      d = seed + 64'(j);
      l = (j == n - 1);
      if (expect_out) exp_q.push_back({l, d});
      beat(d, 4'h0, l);
      if (chk_lat && j == 0) begin
        check("lat_valid", 64'(out_bus.tvalid), 64'd1);
        check("lat_data", out_bus.tdata, d);
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] et, input logic [7:0] pr, input logic [15:0] port,
                            input int n, input logic [63:0] seed, input bit expect_out);
    send_hdr(et, pr, port, -1);
    send_pay(n, seed, expect_out, 1'b0);
  endtask

  task automatic send_runt(input int n);
    for (int i = 0; i < n; i++)
      beat(hdr_line(i, 16'h0800, 8'h11, 16'h1234), 4'h0, (i == n - 1));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_bus.tvalid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    reset_n = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    in_bus.tdata = '0; in_bus.tuser = '0; in_bus.tlast = 1'b0; in_bus.tvalid = 1'b0;
    #12;
    check("rst_in_tready", 64'(in_bus.tready), 64'd0);
    check("rst_out_tvalid", 64'(out_bus.tvalid), 64'd0);
    check("rst_out_tdata", out_bus.tdata, 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: valid frame, port check enabled
    wr(8'd0, 32'h0001_1234);
    send_hdr(16'h0800, 8'h11, 16'h1234, -1);
    send_pay(4, 64'hDEAD_0000_0000_0010, 1'b1, 1'b1);
    drain("t1_drain");
    check("t1_drop", 64'(drop_count), 64'd0);

    // 2: wrong UDP port, dropped without back-pressure
    s0 = stall_cycles;
    send_frame(16'h0800, 8'h11, 16'h4321, 3, 64'h2000, 1'b0);
    drain("t2_drain");
    check("t2_no_stall", 64'(stall_cycles - s0), 64'd0);
    check("t2_drop", 64'(drop_count), CNT_EN ? 64'd1 : 64'd0);

    // 3: bad ethertype, runt, valid frame, and other discard causes
    wr(8'd1, 32'd0);
    check("t3_cleared", 64'(drop_count), 64'd0);
    send_frame(16'h86DD, 8'h11, 16'h1234, 2, 64'h3000, 1'b0);
    send_runt(3);
    send_frame(16'h0800, 8'h11, 16'h1234, 3, 64'h3100, 1'b1);
    drain("t3_drain");
    check("t3_drop2", 64'(drop_count), CNT_EN ? 64'd2 : 64'd0);
    send_runt(6);
    send_frame(16'h0800, 8'h06, 16'h1234, 2, 64'h3200, 1'b0);
    send_hdr(16'h0800, 8'h11, 16'h1234, 1);
    send_pay(2, 64'h3300, 1'b0, 1'b0);
    send_frame(16'h0800, 8'h11, 16'h1234, 1, 64'h3400, 1'b1);
    drain("t3b_drain");
    check("t3_drop5", 64'(drop_count), CNT_EN ? 64'd5 : 64'd0);

    // Port change mid-header applies only to the following frame
    beat(hdr_line(0, 16'h0800, 8'h11, 16'h1234), 4'h0, 1'b0);
    set_stb = 1'b1; set_addr = 8'd0; set_data = 32'h0001_5555;
    beat(hdr_line(1, 16'h0800, 8'h11, 16'h1234), 4'h0, 1'b0);
    set_stb = 1'b0;
    for (int i = 2; i < 6; i++) beat(hdr_line(i, 16'h0800, 8'h11, 16'h1234), 4'h0, 1'b0);
    send_pay(2, 64'h3500, 1'b1, 1'b0);
    send_frame(16'h0800, 8'h11, 16'h1234, 2, 64'h3600, 1'b0);
    drain("cfg_drain");
    check("cfg_drop6", 64'(drop_count), CNT_EN ? 64'd6 : 64'd0);
    wr(8'd0, 32'h0001_1234);

    // 4: output back-pressure, toggled then held
    rdy_mode = 1;
    fork
      send_frame(16'h0800, 8'h11, 16'h1234, 8, 64'h4000, 1'b1);
      begin
        repeat (7) @(posedge clk);
        rdy_mode = 2;
        repeat (5) @(negedge clk);
        check("t4_in_tready_stalled", 64'(in_bus.tready), 64'd0);
        check("t4_out_valid_held", 64'(out_bus.tvalid), 64'd1);
        repeat (15) @(posedge clk);
        rdy_mode = 1;
      end
    join
    rdy_mode = 0;
    drain("t4_drain");

    // 5: reset mid-payload, then clear mid-header
    rdy_mode = 2;
    @(posedge clk); @(posedge clk); #1;
    send_hdr(16'h0800, 8'h11, 16'h1234, -1);
    beat(64'h5000, 4'h0, 1'b0);
    check("t5_pre_valid", 64'(out_bus.tvalid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(out_bus.tvalid), 64'd0);
    check("t5_rst_ready", 64'(in_bus.tready), 64'd0);
    check("t5_rst_data", out_bus.tdata, 64'd0);
    check("t5_rst_last", 64'(out_bus.tlast), 64'd0);
    check("t5_rst_drop", 64'(drop_count), 64'd0);
    exp_q.delete();
    rdy_mode = 0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    send_frame(16'h0800, 8'h11, 16'h9999, 2, 64'h5100, 1'b1);
    drain("t5_post_rst");
    for (int i = 0; i < 3; i++) beat(hdr_line(i, 16'h0800, 8'h11, 16'h0), 4'h0, 1'b0);
    clear = 1'b1;
    beat(hdr_line(3, 16'h0800, 8'h11, 16'h0), 4'h0, 1'b0);
    clear = 1'b0;
    send_frame(16'h0800, 8'h11, 16'h0777, 2, 64'h5200, 1'b1);
    drain("t5_post_clear");
    check("t5_drop", 64'(drop_count), 64'd0);

    // 6: saturation and counter clear
`ifdef DEFRAMER_DROP_CNT_EN
    @(negedge clk);
    force dut.drop_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.drop_q;
    @(posedge clk); #1;
`endif
    send_frame(16'h86DD, 8'h11, 16'h0, 1, 64'h6000, 1'b0);
    drain("t6_drain");
    check("t6_saturate", 64'(drop_count), CNT_EN ? 64'hFFFF_FFFF : 64'd0);
    wr(8'd1, 32'h1);
    check("t6_clear", 64'(drop_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
